// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER MEM-stage load/store unit.
// Access sizes follow RISC-V funct3; addresses at or above IO_BASE are memory-mapped IO.
package otter_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_MRG  = 3'd3,
        ST_WR0  = 3'd4,
        ST_WR1  = 3'd5,
        ST_DONE = 3'd6
    } lsu_state_t;

    localparam logic [2:0] FUNC3_LB  = 3'd0;
    localparam logic [2:0] FUNC3_LH  = 3'd1;
    localparam logic [2:0] FUNC3_LW  = 3'd2;
    localparam logic [2:0] FUNC3_LBU = 3'd4;
    localparam logic [2:0] FUNC3_LHU = 3'd5;

    localparam logic [31:0] IO_BASE_DEFAULT   = 32'h1100_0000;
    localparam logic [31:0] MEM_BYTES_DEFAULT = 32'h0001_0000;

    // Stores only have the three signed encodings; loads add the unsigned pair.
    function automatic logic func3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == FUNC3_LB) || (f3 == FUNC3_LH) || (f3 == FUNC3_LW);
        return (f3 == FUNC3_LB) || (f3 == FUNC3_LH) || (f3 == FUNC3_LW) ||
               (f3 == FUNC3_LBU) || (f3 == FUNC3_LHU);
    endfunction

    function automatic logic [2:0] func3_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/otter_lsu_split_if.sv
// Request/response handshake plus memory port 2 of the OTTER MEM stage.
// master = CPU pipeline and memory side, slave = the load/store unit.
interface otter_lsu_split_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [2:0]  REQ_FUNC3;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_FUNC3, MEM_DOUT2,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_FUNC3, MEM_DOUT2,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );
endinterface

// File: rtl/otter_lsu_lanes.sv
// Combinational byte-lane logic: byte enables across a two-word window, store merge
// into both words, and little-endian load extraction with optional sign extension.
module otter_lsu_lanes
    import otter_lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_buf_i,
    input  logic [31:0] hi_buf_i,
    input  logic [31:0] rd_lo_i,
    input  logic [31:0] rd_hi_i,
    output logic [31:0] wr_word0_o,
    output logic [31:0] wr_word1_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  base_be;
    logic [7:0]  be;
    logic [63:0] wsh;
    logic [31:0] rsh;

    always_comb begin
        case (func3_i[1:0])
            2'd0:    base_be = 8'h01;
            2'd1:    base_be = 8'h03;
            default: base_be = 8'h0F;
        endcase
        be  = base_be << off_i;
        wsh = {32'd0, wdata_i} << {off_i, 3'b000};
        rsh = 32'({rd_hi_i, rd_lo_i} >> {off_i, 3'b000});

        // Bytes outside the enable window keep what was read back.
        wr_word0_o = lo_buf_i;
        wr_word1_o = hi_buf_i;
        for (int i = 0; i < 4; i++) begin
            if (be[i])     wr_word0_o[8*i +: 8] = wsh[8*i +: 8];
            if (be[i + 4]) wr_word1_o[8*i +: 8] = wsh[32 + 8*i +: 8];
        end

        case (func3_i[1:0])
            2'd0:    ld_data_o = func3_i[2] ? {24'd0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
            2'd1:    ld_data_o = func3_i[2] ? {16'd0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            default: ld_data_o = rsh;
        endcase
    end

endmodule

// File: rtl/otter_lsu_split.sv
// OTTER MEM-stage load/store unit: turns any byte/half/word access into word-aligned
// memory cycles, splitting word-spanning accesses and doing read-modify-write for stores.
module otter_lsu_split
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input logic              CLK,
    input logic              RST,
    otter_lsu_split_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
    localparam logic [2:0] S_RD0  = 3'(ST_RD0);
    localparam logic [2:0] S_RD1  = 3'(ST_RD1);
    localparam logic [2:0] S_MRG  = 3'(ST_MRG);
    localparam logic [2:0] S_WR0  = 3'(ST_WR0);
    localparam logic [2:0] S_WR1  = 3'(ST_WR1);
    localparam logic [2:0] S_DONE = 3'(ST_DONE);

    logic [2:0]  state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] addr_q, wdata_q, w0_q, w1_q, lo_buf_q, hi_buf_q;
    logic [2:0]  func3_q;
    logic        we_q, split_q, io_q;

    logic        accept;
    logic [1:0]  req_off;
    logic [2:0]  req_bytes;
    logic [31:0] req_w0, req_w1;
    logic        req_io, req_split, req_bad;

    logic [31:0] rd_lo, rd_hi, wr_word0, wr_word1, ld_data;

    assign accept    = bus.REQ_VALID && (state_q == S_IDLE);
    assign req_off   = bus.REQ_ADDR[1:0];
    assign req_bytes = func3_bytes(bus.REQ_FUNC3[1:0]);
    assign req_w0    = {bus.REQ_ADDR[31:2], 2'b00};
    assign req_w1    = req_w0 + 32'd4;
    assign req_io    = bus.REQ_ADDR >= IO_BASE;
    assign req_split = ({2'b00, req_off} + {1'b0, req_bytes}) > 4'd4;
    // Range check uses the highest word the access would touch, so a split that runs
    // off the end of memory is refused before any strobe goes out.
    assign req_bad   = !func3_legal(bus.REQ_WE, bus.REQ_FUNC3) ||
                       (!req_io && ((req_split ? req_w1 : req_w0) >= MEM_BYTES));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d = req_bad;
                    if (req_bad)
                        state_d = S_DONE;
                    else if (req_io)
                        state_d = bus.REQ_WE ? S_WR0 : S_RD0;
                    else if (bus.REQ_WE && (req_off == 2'd0) && (bus.REQ_FUNC3 == FUNC3_LW))
                        state_d = S_WR0;
                    else
                        state_d = S_RD0;
                end
            end
            S_RD0:   state_d = split_q ? S_RD1 : S_MRG;
            S_RD1:   state_d = S_MRG;
            S_MRG:   state_d = we_q ? S_WR0 : S_DONE;
            S_WR0:   state_d = split_q ? S_WR1 : S_DONE;
            S_WR1:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if ((state_q == S_MRG) && !we_q) rdata_d = io_q ? bus.MEM_DOUT2 : ld_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_q  <= bus.REQ_ADDR;
            wdata_q <= bus.REQ_WDATA;
            func3_q <= bus.REQ_FUNC3;
            we_q    <= bus.REQ_WE;
            w0_q    <= req_w0;
            w1_q    <= req_w1;
            io_q    <= req_io;
            split_q <= req_split && !req_io;
        end
        // MEM_DOUT2 lags the read strobe by one cycle: RD1 sees word0, MRG sees the last read.
        if (state_q == S_RD1) lo_buf_q <= bus.MEM_DOUT2;
        if (state_q == S_MRG) begin
            if (split_q) hi_buf_q <= bus.MEM_DOUT2;
            else         lo_buf_q <= bus.MEM_DOUT2;
        end
    end

    // Loads compute in MRG, before the second read word has been buffered.
    assign rd_lo = split_q ? lo_buf_q : bus.MEM_DOUT2;
    assign rd_hi = split_q ? bus.MEM_DOUT2 : 32'd0;

    otter_lsu_lanes u_lanes (
        .off_i      (addr_q[1:0]),
        .func3_i    (func3_q),
        .wdata_i    (wdata_q),
        .lo_buf_i   (lo_buf_q),
        .hi_buf_i   (hi_buf_q),
        .rd_lo_i    (rd_lo),
        .rd_hi_i    (rd_hi),
        .wr_word0_o (wr_word0),
        .wr_word1_o (wr_word1),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        bus.MEM_ADDR2 = 32'd0;
        bus.MEM_DIN2  = 32'd0;
        case (state_q)
            S_RD0:   bus.MEM_ADDR2 = io_q ? addr_q : w0_q;
            S_RD1:   bus.MEM_ADDR2 = w1_q;
            S_MRG:   bus.MEM_ADDR2 = split_q ? w1_q : (io_q ? addr_q : w0_q);
            S_WR0: begin
                bus.MEM_ADDR2 = io_q ? addr_q : w0_q;
                bus.MEM_DIN2  = io_q ? wdata_q : wr_word0;
            end
            S_WR1: begin
                bus.MEM_ADDR2 = w1_q;
                bus.MEM_DIN2  = wr_word1;
            end
            default: ;
        endcase
    end

    assign bus.REQ_READY  = (state_q == S_IDLE);
    assign bus.RSP_VALID  = (state_q == S_DONE);
    assign bus.RSP_ERR    = (state_q == S_DONE) && err_q;
    assign bus.RSP_RDATA  = rdata_q;
    assign bus.MEM_READ2  = (state_q == S_RD0) || (state_q == S_RD1);
    assign bus.MEM_WRITE2 = (state_q == S_WR0) || (state_q == S_WR1);
    assign bus.MEM_SIZE   = 2'd2;
    assign bus.MEM_SIGN   = 1'b0;

endmodule

// File: tb/tb_otter_lsu_split.sv
// Bench for otter_lsu_split: word memory plus IO model on port 2, scoreboarded responses.
module tb_otter_lsu_split;
    import otter_lsu_pkg::*;

    localparam logic [31:0] IO_B   = 32'h1100_0000;
    localparam logic [31:0] IO_VAL = 32'hCAFE_F00D;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    otter_lsu_split_if bus();

    otter_lsu_split #(.MEM_BYTES(32'h0001_0000), .IO_BASE(IO_B)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int vecs = 0;
    int errs = 0;

    // Memory and IO model; preloads go through poke_* so the array has one writer.
    logic [31:0] mem [0:16383];
    logic        poke_en = 1'b0;
    logic [13:0] poke_idx = 14'd0;
    logic [31:0] poke_data = 32'd0;
    logic [31:0] io_last_addr = 32'd0;
    logic [31:0] io_last_data = 32'd0;

    always @(posedge CLK) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        else if (bus.MEM_WRITE2) begin
            if (bus.MEM_ADDR2 >= IO_B) begin
                io_last_addr <= bus.MEM_ADDR2;
                io_last_data <= bus.MEM_DIN2;
            end else mem[bus.MEM_ADDR2[15:2]] <= bus.MEM_DIN2;
        end
        if (bus.MEM_READ2)
            bus.MEM_DOUT2 <= (bus.MEM_ADDR2 >= IO_B) ? IO_VAL : mem[bus.MEM_ADDR2[15:2]];
    end

    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic both_seen = 1'b0;
    logic misalign_seen = 1'b0;
    always @(negedge CLK) begin
        if (bus.MEM_READ2)  rd_cnt <= rd_cnt + 1;
        if (bus.MEM_WRITE2) wr_cnt <= wr_cnt + 1;
        if (bus.MEM_READ2 && bus.MEM_WRITE2) both_seen <= 1'b1;
        if ((bus.MEM_READ2 || bus.MEM_WRITE2) && (bus.MEM_ADDR2 < IO_B) && (bus.MEM_ADDR2[1:0] != 2'd0))
            misalign_seen <= 1'b1;
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_idx  = a[15:2];
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge CLK); #1;
        poke_en   = 1'b0;
    endtask

    task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic chk, input logic [31:0] exp_rd,
                         input int exp_lat, input int exp_rds, input int exp_wrs);
        exp_t e, g;
        int   lat, rd0, wr0;
        bit   got;
        e.err = exp_err; e.chk = chk; e.rdata = exp_rd; e.lat = exp_lat;
        sb.push_back(e);
        lat = 0;
        while (bus.REQ_READY !== 1'b1 && lat < 20) begin @(posedge CLK); #1; lat++; end
        vecs++;
        if (bus.REQ_READY !== 1'b1) begin errs++; $display("FAIL %s ready: got %b want 1", nm, bus.REQ_READY); end
        bus.REQ_WE = we; bus.REQ_FUNC3 = f3; bus.REQ_ADDR = a; bus.REQ_WDATA = wd;
        bus.REQ_VALID = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
        lat = 1; got = 0;
        while (!got && lat <= 12) begin
            if (bus.RSP_VALID === 1'b1) got = 1;
            else begin @(posedge CLK); #1; lat++; end
        end
        g = sb.pop_front();
        vecs++;
        if (!got) begin
            errs++; $display("FAIL %s timeout: no RSP_VALID within 12 cycles, want latency %0d", nm, g.lat);
        end else begin
            if (lat != g.lat) begin errs++; $display("FAIL %s latency: got %0d want %0d", nm, lat, g.lat); end
            vecs++;
            if (bus.RSP_ERR !== g.err) begin errs++; $display("FAIL %s err: got %b want %b", nm, bus.RSP_ERR, g.err); end
            if (g.chk) begin
                vecs++;
                if (bus.RSP_RDATA !== g.rdata) begin
                    errs++; $display("FAIL %s rdata: got %h want %h", nm, bus.RSP_RDATA, g.rdata);
                end
            end
        end
        vecs++;
        if ((rd_cnt - rd0) != exp_rds) begin errs++; $display("FAIL %s reads: got %0d want %0d", nm, rd_cnt - rd0, exp_rds); end
        vecs++;
        if ((wr_cnt - wr0) != exp_wrs) begin errs++; $display("FAIL %s writes: got %0d want %0d", nm, wr_cnt - wr0, exp_wrs); end
        @(posedge CLK); #1;
        vecs++;
        if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
            errs++; $display("FAIL %s pulse: valid=%b ready=%b want 0/1", nm, bus.RSP_VALID, bus.REQ_READY);
        end
    endtask

    task automatic check_word(input string nm, input logic [31:0] a, input logic [31:0] want);
        vecs++;
        if (mem[a[15:2]] !== want) begin errs++; $display("FAIL %s mem[%h]: got %h want %h", nm, a, mem[a[15:2]], want); end
    endtask

    task automatic test_reset();
        vecs++;
        if (bus.REQ_READY !== 1'b1 || bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0 ||
            bus.MEM_READ2 !== 1'b0 || bus.MEM_WRITE2 !== 1'b0) begin
            errs++; $display("FAIL reset ctl: ready=%b valid=%b err=%b rd=%b wr=%b want 1/0/0/0/0",
                             bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.MEM_READ2, bus.MEM_WRITE2);
        end
        vecs++;
        if (bus.MEM_ADDR2 !== 32'd0 || bus.MEM_DIN2 !== 32'd0 || bus.RSP_RDATA !== 32'd0) begin
            errs++; $display("FAIL reset data: addr=%h din=%h rdata=%h want 0", bus.MEM_ADDR2, bus.MEM_DIN2, bus.RSP_RDATA);
        end
        vecs++;
        if (bus.MEM_SIZE !== 2'd2 || bus.MEM_SIGN !== 1'b0) begin
            errs++; $display("FAIL reset const: size=%0d sign=%b want 2/0", bus.MEM_SIZE, bus.MEM_SIGN);
        end
    endtask

    task automatic test_loads();
        poke(32'h100, 32'h80FF_1234);
        issue("lb_103",  0, FUNC3_LB,  32'h103, 0, 0, 1, 32'hFFFF_FF80, 3, 1, 0);
        issue("lbu_103", 0, FUNC3_LBU, 32'h103, 0, 0, 1, 32'h0000_0080, 3, 1, 0);
        issue("lh_102",  0, FUNC3_LH,  32'h102, 0, 0, 1, 32'hFFFF_80FF, 3, 1, 0);
        issue("lhu_100", 0, FUNC3_LHU, 32'h100, 0, 0, 1, 32'h0000_1234, 3, 1, 0);
        issue("lb_101",  0, FUNC3_LB,  32'h101, 0, 0, 1, 32'h0000_0012, 3, 1, 0);
    endtask

    task automatic test_split_loads();
        poke(32'h100, 32'h1122_3344);
        poke(32'h104, 32'h5566_7788);
        issue("lw_102", 0, FUNC3_LW, 32'h102, 0, 0, 1, 32'h7788_1122, 4, 2, 0);
        issue("lh_103", 0, FUNC3_LH, 32'h103, 0, 0, 1, 32'hFFFF_8811, 4, 2, 0);
        issue("lw_100", 0, FUNC3_LW, 32'h100, 0, 0, 1, 32'h1122_3344, 3, 1, 0);
    endtask

    task automatic test_stores();
        poke(32'h108, 32'h0000_0000);
        poke(32'h10C, 32'h0000_0000);
        issue("sh_103", 1, FUNC3_LH, 32'h103, 32'h0000_BEEF, 0, 0, 0, 6, 2, 2);
        check_word("sh_103_w0", 32'h100, 32'hEF22_3344);
        check_word("sh_103_w1", 32'h104, 32'h5566_77BE);
        issue("sb_101", 1, FUNC3_LB, 32'h101, 32'h1234_565A, 0, 0, 0, 4, 1, 1);
        check_word("sb_101_w0", 32'h100, 32'hEF22_5A44);
        issue("sw_108", 1, FUNC3_LW, 32'h108, 32'hDEAD_BEEF, 0, 0, 0, 2, 0, 1);
        check_word("sw_108_w0", 32'h108, 32'hDEAD_BEEF);
        issue("sw_10A", 1, FUNC3_LW, 32'h10A, 32'hA1B2_C3D4, 0, 0, 0, 6, 2, 2);
        check_word("sw_10A_w0", 32'h108, 32'hC3D4_BEEF);
        check_word("sw_10A_w1", 32'h10C, 32'h0000_A1B2);
    endtask

    task automatic test_io();
        issue("io_sw", 1, FUNC3_LW, 32'h1100_0020, 32'h0000_00A5, 0, 0, 0, 2, 0, 1);
        vecs++;
        if (io_last_addr !== 32'h1100_0020 || io_last_data !== 32'h0000_00A5) begin
            errs++; $display("FAIL io_sw bus: addr=%h din=%h want 11000020/000000a5", io_last_addr, io_last_data);
        end
        issue("io_sb", 1, FUNC3_LB, 32'h1100_0003, 32'h0000_1234, 0, 0, 0, 2, 0, 1);
        vecs++;
        if (io_last_addr !== 32'h1100_0003 || io_last_data !== 32'h0000_1234) begin
            errs++; $display("FAIL io_sb bus: addr=%h din=%h want 11000003/00001234", io_last_addr, io_last_data);
        end
        issue("io_lb", 0, FUNC3_LB, 32'h1100_0001, 0, 0, 1, IO_VAL, 3, 1, 0);
    endtask

    task automatic test_errors();
        poke(32'hFFFC, 32'h0BAD_F00D);
        issue("f3_3_ld",   0, 3'd3, 32'h100, 0, 1, 0, 0, 1, 0, 0);
        issue("f3_6_ld",   0, 3'd6, 32'h100, 0, 1, 0, 0, 1, 0, 0);
        issue("f3_4_st",   1, 3'd4, 32'h100, 32'h1, 1, 0, 0, 1, 0, 0);
        issue("lw_FFFE",   0, FUNC3_LW, 32'hFFFE, 0, 1, 0, 0, 1, 0, 0);
        issue("lh_FFFF",   0, FUNC3_LH, 32'hFFFF, 0, 1, 0, 0, 1, 0, 0);
        issue("lb_10000",  0, FUNC3_LB, 32'h1_0000, 0, 1, 0, 0, 1, 0, 0);
        issue("sw_FFFD",   1, FUNC3_LW, 32'hFFFD, 32'h5, 1, 0, 0, 1, 0, 0);
        issue("lw_FFFC",   0, FUNC3_LW, 32'hFFFC, 0, 0, 1, 32'h0BAD_F00D, 3, 1, 0);
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  hit, rsp;
        poke(32'h110, 32'h0101_0101);
        poke(32'h114, 32'h0202_0202);
        bus.REQ_WE = 1'b1; bus.REQ_FUNC3 = FUNC3_LH; bus.REQ_ADDR = 32'h113; bus.REQ_WDATA = 32'h0000_CDCD;
        bus.REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
        n = 0; hit = 0;
        while (!hit && n < 12) begin
            if (bus.MEM_WRITE2 === 1'b1 && bus.MEM_ADDR2 === 32'h114) hit = 1;
            else begin @(posedge CLK); #1; n++; end
        end
        vecs++;
        if (!hit) begin errs++; $display("FAIL abort reach_wr1: no write to 00000114 within 12 cycles"); end
        RST = 1'b1;
        #1;
        vecs++;
        if (bus.MEM_WRITE2 !== 1'b0) begin errs++; $display("FAIL abort strobe: MEM_WRITE2=%b want 0", bus.MEM_WRITE2); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        vecs++;
        if (bus.REQ_READY !== 1'b1) begin errs++; $display("FAIL abort ready: got %b want 1", bus.REQ_READY); end
        rsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (bus.RSP_VALID === 1'b1) rsp = 1;
        end
        vecs++;
        if (rsp) begin errs++; $display("FAIL abort rsp: RSP_VALID seen for aborted request"); end
        check_word("abort_w1", 32'h114, 32'h0202_0202);
        issue("post_abort_lw", 0, FUNC3_LW, 32'h104, 0, 0, 1, 32'h5566_77BE, 3, 1, 0);
    endtask

    task automatic test_invariants();
        vecs++;
        if (both_seen !== 1'b0) begin errs++; $display("FAIL both_strobes: got %b want 0", both_seen); end
        vecs++;
        if (misalign_seen !== 1'b0) begin errs++; $display("FAIL mem_align: got %b want 0", misalign_seen); end
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_ADDR  = 32'd0;
        bus.REQ_WDATA = 32'd0;
        bus.REQ_FUNC3 = 3'd0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_loads();
        test_split_loads();
        test_stores();
        test_io();
        test_errors();
        test_reset_abort();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
